// File: rtl/seq_scan_pkg.sv
// Shared types and constants for the word-level serial pattern scanner.
package seq_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_PAT_W = 4;
  localparam logic [DEFAULT_PAT_W-1:0] DEFAULT_PAT = 4'b1011;

  // Width able to hold any count 0..word_w
  function automatic int unsigned cnt_width(input int unsigned word_w);
    return $clog2(word_w + 1);
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// Serial overlapping Mealy matcher: keeps the last PAT_W-1 bits plus a fill
// counter so a match is only reported once PAT_W bits have been seen.
module seq_match_core
  import seq_scan_pkg::*;
#(
  parameter int unsigned PAT_W = DEFAULT_PAT_W,
  parameter logic [PAT_W-1:0] PAT = PAT_W'(DEFAULT_PAT)
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clear,
  input  logic din,
  output logic match
);

  localparam int unsigned HIST_W = PAT_W - 1;
  localparam int unsigned FILL_W = $clog2(PAT_W);

  logic [HIST_W-1:0] hist;
  logic [FILL_W-1:0] fill;
  logic [PAT_W-1:0]  window;

  assign window = {hist, din};
  assign match  = en && (fill == FILL_W'(HIST_W)) && (window == PAT);

  // History shifts only while a word is being scanned; clear always wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
    end else if (en) begin
      hist <= window[HIST_W-1:0];
      if (fill != FILL_W'(HIST_W)) begin
        fill <= fill + FILL_W'(1);
      end
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Word-level controller: accepts a word, shifts it MSB-first through the
// matcher and reports the match count. Optional first_pos output: SEQSCAN_FIRSTPOS_EN.
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned PAT_W  = DEFAULT_PAT_W,
  parameter logic [PAT_W-1:0] PAT = PAT_W'(DEFAULT_PAT),
  parameter int unsigned CNT_W  = cnt_width(WORD_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  input  logic              clear,
  output logic              in_bit,
  output logic              match,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef SEQSCAN_FIRSTPOS_EN
  output logic [CNT_W-1:0]  first_pos,
`endif
  output logic [CNT_W-1:0]  match_count
);

  state_t            state;
  state_t            state_next;
  logic [WORD_W-1:0] word_q;
  logic [CNT_W-1:0]  idx;
  logic [CNT_W-1:0]  count;
  logic              accept;
  logic              shifting;

  assign accept      = in_valid && (state == IDLE);
  assign shifting    = (state == SHIFT);
  assign match_count = count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    in_bit     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        in_bit = word_q[WORD_W-1];
        if (clear) begin
          state_next = IDLE;
        end else if (idx == '0) begin
          state_next = REPORT;
        end
      end
      REPORT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Word is shifted left so the bit under test is always the MSB
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= '0;
      idx    <= '0;
      count  <= '0;
    end else if (accept) begin
      word_q <= in_word;
      idx    <= CNT_W'(WORD_W - 1);
      count  <= '0;
    end else if (shifting) begin
      word_q <= word_q << 1;
      idx    <= idx - CNT_W'(1);
      if (match) begin
        count <= count + CNT_W'(1);
      end
    end
  end

`ifdef SEQSCAN_FIRSTPOS_EN
  // All-ones means no match yet; it can never be a real bit position
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_pos <= '1;
    end else if (accept) begin
      first_pos <= '1;
    end else if (shifting && match && (first_pos == '1)) begin
      first_pos <= CNT_W'(WORD_W - 1) - idx;
    end
  end
`endif

  seq_match_core #(
    .PAT_W (PAT_W),
    .PAT   (PAT)
  ) u_match (
    .clk   (clk),
    .reset (reset),
    .en    (shifting),
    .clear (clear),
    .din   (in_bit),
    .match (match)
  );

endmodule

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Word-level controller for the serial pattern detector. Accepts parallel words over a valid/ready handshake and shifts them MSB-first, one bit per clock, through a programmable overlapping Mealy pattern matcher. Counts the pattern matches in each word and returns the count over a second valid/ready handshake. Sits between a parallel producer (bus or FIFO) and the serial detection datapath, so the detector can be driven by word traffic instead of a bit-level stimulus.

## Interface
- WORD_W, 16, bits per input word; must be ≥ PAT_W.
- PAT_W, 4, pattern length in bits, 2..8.
- PAT, 4'b1011, pattern; the MSB is the first bit in time.
- CNT_W, $clog2(WORD_W+1), width of match count and position.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; returns the block to IDLE immediately.
- in_valid  in  1  producer has a word.
- in_ready  out  1  block can accept a word; equals state==IDLE.
- in_word  in  WORD_W  word to scan; bit WORD_W-1 is shifted first.
- clear  in  1  synchronous; flushes detector history.
- in_bit  out  1  serial bit currently presented to the matcher; debug only.
- match  out  1  Mealy output: high in the SHIFT cycle whose bit completes PAT.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- match_count  out  CNT_W  matches in the last scanned word.

## Operation
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch in_word, set bit index to WORD_W-1, go to SHIFT.
  - SHIFT: each cycle present word[idx] on in_bit. The matcher evaluates it combinationally and updates its history on the edge. The count increments on every edge where match=1. After the edge that consumes idx=0, go to REPORT.
  - REPORT: out_valid=1, match_count held. On out_valid&out_ready, go to IDLE.
- The matcher keeps the last PAT_W-1 bits plus a fill counter. A match needs at least PAT_W bits of history since reset or clear.
  - Overlapping matches count, so 1011011 yields 2.
  - History persists across words, so a pattern spanning two words matches in the second word.
- The count is cleared on word accept. It cannot overflow, because at most WORD_W matches fit in one word.
- clear:
  - In IDLE or REPORT: flushes the history only.
  - In SHIFT: flushes the history, aborts the word and returns to IDLE with no report.
- clear and an in_valid handshake in the same IDLE cycle: clear takes effect first, so the accepted word starts with empty history.
- Reset values: state IDLE, in_ready 1, out_valid 0, match 0, in_bit 0, match_count 0, history empty.

## Timing
- The accept edge is T.
- SHIFT occupies cycles T+1 .. T+WORD_W.
- out_valid rises after edge T+WORD_W, so latency is WORD_W cycles.
- Minimum throughput is one word per WORD_W+2 cycles. The path is accept, SHIFT×WORD_W, then REPORT with out_ready=1 for one cycle, then IDLE.
- match is combinational from in_bit and the history, valid only in SHIFT, and 0 elsewhere.
- match_count and out_valid are registered. Both stay stable while out_ready=0.
- Asserting reset mid-SHIFT drops the word silently.

## Configuration
- SEQSCAN_FIRSTPOS_EN defined:
  - Adds output first_pos [CNT_W-1:0]. It holds the SHIFT cycle index (0 = first bit shifted) at which the first match in the word completed.
  - Reads all-ones when the word had no match.
  - Valid with out_valid; reset value all-ones.
- Undefined: the port and its logic are absent, and all other behaviour is identical.

## Structure
- Package seq_scan_pkg holds:
  - the state enum (IDLE, SHIFT, REPORT),
  - the default pattern constant 4'b1011,
  - the CNT_W helper function.
- Sub-module seq_match_core holds the serial matcher: history shift register, fill counter, combinational match, and flush on clear.
- The controller holds the FSM, word register, index, count and first_pos.

## Test plan
All scenarios use default parameters and SEQSCAN_FIRSTPOS_EN defined.
- Reset, then word 16'hB000 → after 16 cycles out_valid=1, match_count=1, first_pos=3.
- Word 16'hB6C0 (bits 1011011011000000) → match_count=3, first_pos=3; match pulses in SHIFT cycles 3, 6 and 9.
- Word 16'h0005, then 16'h8000 with no clear → counts 0, then 1 with first_pos=0 (cross-word match).
- Same pair with clear pulsed in IDLE between the words → counts 0, then 0.
- out_ready held low 5 cycles in REPORT → out_valid and match_count stable, in_ready=0; accept resumes one cycle after out_ready rises.
- reset asserted after 8 SHIFT bits of 16'hFFFF → in_ready=1 and out_valid=0 immediately; the next word 16'hB000 reports count 1 and first_pos 3.
